// File: rtl/mem_stage.sv
// EX/MEM pipeline register and memory-access stage: issues loads and stores on a
// single-outstanding req/ack bus, aligns store lanes, and extends load data for WB.
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_en_i,
    input  logic                  mem_rw_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [DATA_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [REG_WIDTH-1:0]  gprs_waddr_i,
    input  logic [DATA_WIDTH-1:0] gprs_wdata_i,
    input  logic                  flush_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_strb_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    output logic [REG_WIDTH-1:0]  gprs_waddr_o,
    output logic [DATA_WIDTH-1:0] gprs_wdata_o,
    output logic                  misalign_o,
    output logic                  stall
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [0:0]            state_reg;
    logic                  bus_req_reg;
    logic                  bus_we_reg;
    logic [DATA_WIDTH-1:0] bus_addr_reg;
    logic [DATA_WIDTH-1:0] bus_wdata_reg;
    logic [3:0]            bus_strb_reg;
    logic [REG_WIDTH-1:0]  gprs_waddr_reg;
    logic [DATA_WIDTH-1:0] gprs_wdata_reg;
    logic                  misalign_reg;

    // Attributes of the in-flight access, needed when the ack arrives.
    logic [REG_WIDTH-1:0]  rd_reg;
    logic                  load_reg;
    logic                  unsigned_reg;
    logic [1:0]            size_reg;
    logic [1:0]            lane_reg;
    logic                  kill_reg;

    logic                  misaligned;
    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [3:0]            store_strb;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  load_wb;

    assign stall = (state_reg == BUSY) && !bus_ack_i;

    assign lane       = mem_addr_i[1:0];
    assign misaligned = ((mem_size_i == SIZE_HALF) && mem_addr_i[0]) ||
                        (mem_size_i[1] && (mem_addr_i[1:0] != 2'b00));

    always_comb begin
        store_wdata = mem_data_i;
        store_strb  = 4'b1111;
        case (mem_size_i)
            SIZE_BYTE: begin
                store_wdata = {4{mem_data_i[7:0]}};
                store_strb  = 4'b0001 << lane;
            end
            SIZE_HALF: begin
                store_wdata = {2{mem_data_i[15:0]}};
                store_strb  = 4'b0011 << lane;
            end
            default: begin
                store_wdata = mem_data_i;
                store_strb  = 4'b1111;
            end
        endcase
        if (!mem_rw_i) begin
            store_strb = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = bus_rdata_i[7:0];
        case (lane_reg)
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            2'd3:    ld_byte = bus_rdata_i[31:24];
            default: ld_byte = bus_rdata_i[7:0];
        endcase
        ld_half = lane_reg[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (size_reg)
            SIZE_BYTE: load_ext = unsigned_reg ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_ext = unsigned_reg ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:   load_ext = bus_rdata_i;
        endcase
    end

    // A flush in the ack cycle is still "flush while BUSY" for the in-flight load.
    assign load_wb = (state_reg == BUSY) && load_reg && !kill_reg && !flush_i &&
                     (rd_reg != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= '0;
            bus_wdata_reg  <= '0;
            bus_strb_reg   <= 4'b0000;
            gprs_waddr_reg <= '0;
            gprs_wdata_reg <= '0;
            misalign_reg   <= 1'b0;
            rd_reg         <= '0;
            load_reg       <= 1'b0;
            unsigned_reg   <= 1'b0;
            size_reg       <= 2'b00;
            lane_reg       <= 2'b00;
            kill_reg       <= 1'b0;
        end else if (stall) begin
            if (flush_i) begin
                kill_reg <= 1'b1;
            end
        end else begin
            state_reg      <= IDLE;
            bus_req_reg    <= 1'b0;
            gprs_waddr_reg <= '0;
            gprs_wdata_reg <= '0;
            misalign_reg   <= 1'b0;
            kill_reg       <= 1'b0;
            if (!flush_i && mem_en_i) begin
                if (misaligned) begin
                    misalign_reg <= 1'b1;
                end else begin
                    state_reg     <= BUSY;
                    bus_req_reg   <= 1'b1;
                    bus_we_reg    <= mem_rw_i;
                    bus_addr_reg  <= {mem_addr_i[DATA_WIDTH-1:2], 2'b00};
                    bus_wdata_reg <= store_wdata;
                    bus_strb_reg  <= store_strb;
                    rd_reg        <= gprs_waddr_i;
                    load_reg      <= !mem_rw_i;
                    unsigned_reg  <= mem_unsigned_i;
                    size_reg      <= mem_size_i;
                    lane_reg      <= lane;
                end
            end else if (!flush_i && (gprs_waddr_i != '0)) begin
                gprs_waddr_reg <= gprs_waddr_i;
                gprs_wdata_reg <= gprs_wdata_i;
            end
            // The completing load owns the single writeback port on its ack edge.
            if (load_wb) begin
                gprs_waddr_reg <= rd_reg;
                gprs_wdata_reg <= load_ext;
            end
        end
    end

    assign bus_req_o    = bus_req_reg;
    assign bus_we_o     = bus_we_reg;
    assign bus_addr_o   = bus_addr_reg;
    assign bus_wdata_o  = bus_wdata_reg;
    assign bus_strb_o   = bus_strb_reg;
    assign gprs_waddr_o = gprs_waddr_reg;
    assign gprs_wdata_o = gprs_wdata_reg;
    assign misalign_o   = misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: one task per scenario, inline comparisons.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_en_i;
    logic        mem_rw_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [4:0]  gprs_waddr_i;
    logic [31:0] gprs_wdata_i;
    logic        flush_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_strb_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [4:0]  gprs_waddr_o;
    logic [31:0] gprs_wdata_o;
    logic        misalign_o;
    logic        stall;

    int checks;
    int failures;

    mem_stage #(.DATA_WIDTH(32), .REG_WIDTH(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_en_i       (mem_en_i),
        .mem_rw_i       (mem_rw_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .gprs_waddr_i   (gprs_waddr_i),
        .gprs_wdata_i   (gprs_wdata_i),
        .flush_i        (flush_i),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_strb_o     (bus_strb_o),
        .bus_ack_i      (bus_ack_i),
        .bus_rdata_i    (bus_rdata_i),
        .gprs_waddr_o   (gprs_waddr_o),
        .gprs_wdata_o   (gprs_wdata_o),
        .misalign_o     (misalign_o),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input logic en, input logic rw, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic [31:0] wd);
        mem_en_i       = en;
        mem_rw_i       = rw;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        mem_addr_i     = addr;
        mem_data_i     = data;
        gprs_waddr_i   = rd;
        gprs_wdata_i   = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush_i = 1'b0;
        bus_ack_i = 1'b0;
        bus_rdata_i = 32'h0;
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
        step();
        checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o} !== 70'h0) begin
            failures++;
            $display("FAIL reset_bus got req=%b we=%b addr=%h wdata=%h strb=%b want all 0",
                     bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o);
        end
        checks++;
        if ({gprs_waddr_o, gprs_wdata_o, misalign_o, stall} !== 39'h0) begin
            failures++;
            $display("FAIL reset_wb got waddr=%0d wdata=%h mis=%b stall=%b want all 0",
                     gprs_waddr_o, gprs_wdata_o, misalign_o, stall);
        end
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_alu();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd5, 32'h0000_1234);
        step();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (gprs_waddr_o !== 5'd5 || gprs_wdata_o !== 32'h0000_1234) begin
            failures++;
            $display("FAIL alu_wb got rd=%0d data=%h want rd=5 data=00001234", gprs_waddr_o, gprs_wdata_o);
        end
        checks++;
        if (stall !== 1'b0 || bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL alu_nostall got stall=%b req=%b want 0 0", stall, bus_req_o);
        end
        step();
        checks++;
        if (gprs_waddr_o !== 5'd0 || gprs_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL alu_bubble got rd=%0d data=%h want 0 0", gprs_waddr_o, gprs_wdata_o);
        end
        // A flushed ALU op must not write back.
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd9, 32'h0000_5555);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (gprs_waddr_o !== 5'd0 || gprs_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL alu_flush got rd=%0d data=%h want 0 0", gprs_waddr_o, gprs_wdata_o);
        end
        $display("test_alu done");
    endtask

    task automatic test_lw();
        int stall_cycles;
        stall_cycles = 0;
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 32'h0);
        step();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_addr_o !== 32'h100 || bus_strb_o !== 4'b0000) begin
            failures++;
            $display("FAIL lw_issue got req=%b we=%b addr=%h strb=%b want 1 0 00000100 0000",
                     bus_req_o, bus_we_o, bus_addr_o, bus_strb_o);
        end
        checks++;
        if (gprs_waddr_o !== 5'd0) begin
            failures++;
            $display("FAIL lw_busy_wb got rd=%0d want 0", gprs_waddr_o);
        end
        for (int c = 0; c < 2; c++) begin
            if (stall === 1'b1) stall_cycles++;
            if (c == 0) step();
        end
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        #1;
        if (stall === 1'b1) stall_cycles++;
        checks++;
        if (stall_cycles != 2) begin
            failures++;
            $display("FAIL lw_stall_cycles got %0d want 2", stall_cycles);
        end
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL lw_hold got req=%b addr=%h want 1 00000100", bus_req_o, bus_addr_o);
        end
        step();
        bus_ack_i = 1'b0;
        checks++;
        if (gprs_waddr_o !== 5'd7 || gprs_wdata_o !== 32'hDEAD_BEEF || bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL lw_wb got rd=%0d data=%h req=%b want 7 deadbeef 0",
                     gprs_waddr_o, gprs_wdata_o, bus_req_o);
        end
        step();
        $display("test_lw done");
    endtask

    task automatic test_loads_ext();
        logic [31:0] exp_data [3];
        logic        uns_tab  [3];
        logic [1:0]  size_tab [3];
        logic [31:0] addr_tab [3];
        logic [31:0] rdata_tab[3];
        exp_data[0] = 32'hFFFF_FF80; uns_tab[0] = 1'b0; size_tab[0] = 2'b00; addr_tab[0] = 32'h203; rdata_tab[0] = 32'h8012_3456;
        exp_data[1] = 32'h0000_0080; uns_tab[1] = 1'b1; size_tab[1] = 2'b00; addr_tab[1] = 32'h203; rdata_tab[1] = 32'h8012_3456;
        exp_data[2] = 32'hFFFF_8001; uns_tab[2] = 1'b0; size_tab[2] = 2'b01; addr_tab[2] = 32'h402; rdata_tab[2] = 32'h8001_1234;
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, 1'b0, size_tab[i], uns_tab[i], addr_tab[i], 32'h0, 5'd3, 32'h0);
            step();
            set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
            bus_ack_i = 1'b1;
            bus_rdata_i = rdata_tab[i];
            step();
            bus_ack_i = 1'b0;
            checks++;
            if (gprs_waddr_o !== 5'd3 || gprs_wdata_o !== exp_data[i]) begin
                failures++;
                $display("FAIL load_ext[%0d] got rd=%0d data=%h want rd=3 data=%h",
                         i, gprs_waddr_o, gprs_wdata_o, exp_data[i]);
            end
        end
        $display("test_loads_ext done");
    endtask

    task automatic test_stores();
        set_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h0000_ABCD, 5'd9, 32'h0);
        step();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h300 ||
            bus_wdata_o !== 32'hABCD_ABCD || bus_strb_o !== 4'b1100) begin
            failures++;
            $display("FAIL sh_issue got req=%b we=%b addr=%h wdata=%h strb=%b want 1 1 00000300 abcdabcd 1100",
                     bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o);
        end
        bus_ack_i = 1'b1;
        step();
        bus_ack_i = 1'b0;
        checks++;
        if (gprs_waddr_o !== 5'd0 || bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL sh_done got rd=%0d req=%b want 0 0", gprs_waddr_o, bus_req_o);
        end
        set_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_565A, 5'd0, 32'h0);
        step();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (bus_addr_o !== 32'h200 || bus_wdata_o !== 32'h5A5A_5A5A || bus_strb_o !== 4'b0010) begin
            failures++;
            $display("FAIL sb_issue got addr=%h wdata=%h strb=%b want 00000200 5a5a5a5a 0010",
                     bus_addr_o, bus_wdata_o, bus_strb_o);
        end
        bus_ack_i = 1'b1;
        step();
        bus_ack_i = 1'b0;
        $display("test_stores done");
    endtask

    task automatic test_misalign();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd4, 32'h0);
        step();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (misalign_o !== 1'b1 || bus_req_o !== 1'b0 || gprs_waddr_o !== 5'd0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse got mis=%b req=%b rd=%0d stall=%b want 1 0 0 0",
                     misalign_o, bus_req_o, gprs_waddr_o, stall);
        end
        step();
        checks++;
        if (misalign_o !== 1'b0 || bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL misalign_clear got mis=%b req=%b want 0 0", misalign_o, bus_req_o);
        end
        $display("test_misalign done");
    endtask

    task automatic test_ack_idle();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h1111_2222;
        step();
        bus_ack_i = 1'b0;
        checks++;
        if (bus_req_o !== 1'b0 || gprs_waddr_o !== 5'd0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle got req=%b rd=%0d stall=%b want 0 0 0", bus_req_o, gprs_waddr_o, stall);
        end
        $display("test_ack_idle done");
    endtask

    task automatic test_back_to_back();
        set_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 5'd0, 32'h0);
        step();
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h10 || bus_we_o !== 1'b1 || bus_strb_o !== 4'b1111 ||
            bus_wdata_o !== 32'h1122_3344) begin
            failures++;
            $display("FAIL b2b_sw got req=%b addr=%h we=%b strb=%b wdata=%h want 1 00000010 1 1111 11223344",
                     bus_req_o, bus_addr_o, bus_we_o, bus_strb_o, bus_wdata_o);
        end
        bus_ack_i = 1'b1;
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0, 5'd6, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ack_stall got %b want 0", stall);
        end
        step();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h14 || bus_we_o !== 1'b0 || bus_strb_o !== 4'b0000 ||
            gprs_waddr_o !== 5'd0) begin
            failures++;
            $display("FAIL b2b_lw got req=%b addr=%h we=%b strb=%b rd=%0d want 1 00000014 0 0000 0",
                     bus_req_o, bus_addr_o, bus_we_o, bus_strb_o, gprs_waddr_o);
        end
        flush_i = 1'b1;
        bus_rdata_i = 32'hCAFE_F00D;
        step();
        flush_i = 1'b0;
        bus_ack_i = 1'b0;
        checks++;
        if (bus_req_o !== 1'b0 || gprs_waddr_o !== 5'd0 || gprs_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL b2b_flush got req=%b rd=%0d data=%h want 0 0 0",
                     bus_req_o, gprs_waddr_o, gprs_wdata_o);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_busy();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 5'd8, 32'h0);
        step();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (bus_req_o !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL rstb_busy got req=%b stall=%b want 1 1", bus_req_o, stall);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o, gprs_waddr_o, gprs_wdata_o,
             misalign_o, stall} !== 109'h0) begin
            failures++;
            $display("FAIL rstb_outputs got req=%b addr=%h strb=%b rd=%0d data=%h mis=%b stall=%b want all 0",
                     bus_req_o, bus_addr_o, bus_strb_o, gprs_waddr_o, gprs_wdata_o, misalign_o, stall);
        end
        rst_n = 1'b1;
        step();
        $display("test_reset_busy done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_alu();
        test_lw();
        test_loads_ext();
        test_stores();
        test_misalign();
        test_ack_idle();
        test_back_to_back();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
